// File: rtl/pong_pkg.sv
// Shared pong constants: playfield geometry, paddle step and movement encodings.
package pong_pkg;
  localparam int SCREEN_W_DEF = 640;
  localparam int PADDLE_W_DEF = 80;
  localparam int STEP_DEF     = 8;
  localparam int XMAX_DEF     = SCREEN_W_DEF - PADDLE_W_DEF;
  localparam int XCTR_DEF     = XMAX_DEF / 2;

  typedef enum logic [1:0] {
    DIR_IDLE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } move_dir_e;
endpackage

// File: rtl/step_accum.sv
// Saturating signed pending-step counter fed by left/right pulses.
module step_accum
  import pong_pkg::*;
#(
  parameter int MAX_PEND = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic left_op,
  input  logic right_op,
  input  logic consume,
  input  logic clear,
  input  logic flush,
  output logic pend_pos,
  output logic pend_neg
);
  localparam logic signed [4:0] PMAX = 5'(MAX_PEND);

  logic signed [3:0] pend;
  logic signed [4:0] delta, base, sum, pend_nxt;

  always_comb begin
    delta = 5'sd0;
    if (right_op && !left_op)      delta = 5'sd1;
    else if (left_op && !right_op) delta = -5'sd1;

    // base is the counter after any step the paddle just applied
    base = {pend[3], pend};
    if (clear)        base = 5'sd0;
    else if (consume) base = pend_pos ? base - 5'sd1 : base + 5'sd1;

    sum = base + delta;
    pend_nxt = sum;
    if (sum > PMAX)        pend_nxt = PMAX;
    else if (sum < -PMAX)  pend_nxt = -PMAX;
    if (flush)             pend_nxt = 5'sd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 4'sd0;
    else        pend <= pend_nxt[3:0];
  end

  assign pend_pos = !pend[3] && (pend != 4'sd0);
  assign pend_neg = pend[3];
endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position register: applies one queued step per frame tick, clamped to the playfield.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int PADDLE_W = PADDLE_W_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int MAX_PEND = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           left_op,
  input  logic           right_op,
  input  logic           frame_tick,
  input  logic           center,
  output logic [X_W-1:0] paddle_x,
  output logic [1:0]     move_dir,
  output logic           at_left,
  output logic           at_right,
  output logic           wall_hit
);
  localparam int XMAX = SCREEN_W - PADDLE_W;
  localparam int XCTR = XMAX / 2;
  localparam logic [X_W:0]   XMAX_W = (X_W+1)'(XMAX);
  localparam logic [X_W:0]   STEP_W = (X_W+1)'(STEP);
  localparam logic [X_W-1:0] XMAX_X = X_W'(XMAX);
  localparam logic [X_W-1:0] XCTR_X = X_W'(XCTR);
  localparam logic [X_W-1:0] STEP_X = X_W'(STEP);

  logic           pend_pos, pend_neg, consume, clear, wall_nxt;
  logic [X_W:0]   cand_up;
  logic [X_W-1:0] x_nxt;

  step_accum #(.MAX_PEND(MAX_PEND)) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .left_op  (left_op),
    .right_op (right_op),
    .consume  (consume),
    .clear    (clear),
    .flush    (center),
    .pend_pos (pend_pos),
    .pend_neg (pend_neg)
  );

  always_comb begin
    cand_up  = {1'b0, paddle_x} + STEP_W;
    x_nxt    = paddle_x;
    wall_nxt = 1'b0;
    consume  = 1'b0;
    clear    = 1'b0;
    if (center) begin
      x_nxt = XCTR_X;
    end else if (frame_tick && pend_pos) begin
      if (cand_up >= XMAX_W) begin
        // landing exactly on the wall is not a hit; overshoot or already there is
        x_nxt    = XMAX_X;
        clear    = 1'b1;
        wall_nxt = (cand_up != XMAX_W);
      end else begin
        x_nxt   = cand_up[X_W-1:0];
        consume = 1'b1;
      end
    end else if (frame_tick && pend_neg) begin
      if (paddle_x < STEP_X) begin
        x_nxt    = '0;
        clear    = 1'b1;
        wall_nxt = 1'b1;
      end else begin
        x_nxt   = paddle_x - STEP_X;
        consume = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddle_x <= XCTR_X;
      at_left  <= 1'b0;
      at_right <= 1'b0;
      wall_hit <= 1'b0;
    end else begin
      paddle_x <= x_nxt;
      at_left  <= (x_nxt == '0);
      at_right <= (x_nxt == XMAX_X);
      wall_hit <= wall_nxt;
    end
  end

  always_comb begin
    move_dir = DIR_IDLE;
    if (pend_neg)      move_dir = DIR_LEFT;
    else if (pend_pos) move_dir = DIR_RIGHT;
  end
endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Downstream consumer of the dip-switch decoder's left_op / right_op one-cycle pulses.
- Turns those pulses into a bounded horizontal paddle position for the pong renderer and collision logic.
- Pulses are queued in a saturating signed pending-step counter. One step of STEP pixels is applied per frame_tick, clamped to the playfield.

Parameters:
- X_W, 10: width of the position bus.
- SCREEN_W, 640: playfield width in pixels.
- PADDLE_W, 80: paddle width in pixels.
- STEP, 8: pixels moved per applied step.
- MAX_PEND, 7: saturation magnitude of the pending-step counter (4-bit signed).

Ports:
- clk  in  1: system clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- left_op  in  1: one-cycle pulse, request one step left.
- right_op  in  1: one-cycle pulse, request one step right.
- frame_tick  in  1: one-cycle strobe, apply at most one step.
- center  in  1: one-cycle recentre request.
- paddle_x  out  X_W: paddle left-edge x coordinate.
- move_dir  out  2: 00 idle, 01 left pending, 10 right pending (11 never).
- at_left  out  1: paddle_x == 0.
- at_right  out  1: paddle_x == XMAX.
- wall_hit  out  1: one-cycle pulse when a step was clamped.

Behaviour:
- Derived constants: XMAX = SCREEN_W-PADDLE_W = 560; XCTR = XMAX/2 = 280.
- Reset (async assert, sync deassert on clk):
  - paddle_x = XCTR, pend = 0, move_dir = 00.
  - at_left = 0, at_right = 0, wall_hit = 0.
- Pulse decode per cycle:
  - delta = +1 if right_op only; -1 if left_op only.
  - delta = 0 if both or neither (simultaneous pulses cancel).
- pend update, no frame_tick: pend <= sat(pend + delta) within [-MAX_PEND, +MAX_PEND]. Pulses beyond saturation are dropped.
- frame_tick with pend > 0:
  - cand = paddle_x + STEP, computed at X_W+1 bits (no wrap).
  - If cand >= XMAX: paddle_x <= XMAX, pend base = 0, wall_hit <= 1 only if the step was actually clamped (cand > XMAX, or paddle_x was already XMAX).
  - Otherwise: paddle_x <= cand, pend base = pend-1.
- frame_tick with pend < 0: mirror of the above.
  - If paddle_x < STEP: paddle_x <= 0, pend base = 0, wall_hit on clamp (paddle_x < STEP, including already 0).
  - Otherwise: paddle_x <= paddle_x-STEP, pend base = pend+1.
- frame_tick with pend == 0: position unchanged, no wall_hit.
- Same-cycle pulse with frame_tick: pend <= sat(base + delta). The pulse is never lost unless saturated.
- center: highest priority. paddle_x <= XCTR, pend <= 0, wall_hit <= 0. Same-cycle pulses and frame_tick are ignored.
- Latency:
  - paddle_x, at_left, at_right and wall_hit are registered; they change on the edge after the frame_tick cycle.
  - move_dir is registered from next pend: 01 if pend<0, 10 if pend>0, else 00.
- at_left / at_right are registered compare flags, consistent with paddle_x in the same cycle.
- wall_hit is high for exactly one cycle per clamped tick.
- paddle_x never leaves [0, XMAX] under any input sequence.
- Reset mid-move: immediate return to reset values. Queued steps are discarded.

Decomposition:
- Shared package pong_pkg:
  - SCREEN_W, PADDLE_W, STEP defaults.
  - Derived XMAX / XCTR.
  - move_dir encodings DIR_IDLE, DIR_LEFT, DIR_RIGHT.
- One sub-module, step_accum:
  - Owns the pulse decode and the saturating signed pend counter.
  - Inputs: delta, consume, clear.
  - Outputs: pend sign and zero flags.
- paddle_ctrl owns the position register, clamping and flags.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> paddle_x=280, move_dir=00, at_left=0, at_right=0, wall_hit=0. Releasing reset changes nothing.
- Single step: right_op pulse, then frame_tick 4 cycles later -> move_dir=10 until the tick; paddle_x=288 on the edge after the tick; move_dir=00.
- Saturation: 10 left_op pulses, then 9 frame_ticks -> move_dir=01 after the first pulse. paddle_x steps 272,264,...,224 over 7 ticks, then holds 224. move_dir=00 after the 7th tick.
- Right wall: from paddle_x=552 with pend=+3, frame_tick -> paddle_x=560, at_right=1, pend=0, no wall_hit. Then right_op and frame_tick -> paddle_x stays 560, wall_hit pulses once, pend=0.
- Simultaneous events:
  - left_op and right_op in the same cycle -> pend unchanged.
  - right_op coincident with frame_tick at pend=+1 -> paddle_x+8, pend=+1 afterwards.
  - center with frame_tick at pend=+5 -> paddle_x=280, pend=0.
- Async reset mid-move: pend=+4 at paddle_x=400, drop rst_n between clk edges -> outputs reach reset values without a clock edge. After release, frame_tick leaves paddle_x=280.
